mem_port_arbiter: RTL and testbench

- Shares the processor's single-port instruction/data memory between two requesters: the instruction-fetch port (I) and the load/store port (D).
- Sits between the processor state machine and the memory array.
- Accepts one request at a time through a valid/ready handshake and drives a request/acknowledge memory interface.
- Returns the memory read data to whichever requester issued the request.
- Ties between I and D are resolved round-robin.

---
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one request/ack memory port between fetch (I) and load/store (D).
// Optional build macro MEM_ARB_TIMEOUT_EN aborts an access after TIMEOUT unacknowledged cycles with rsp_err.
module mem_port_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_req_valid,
   output logic                  i_req_ready,
   input  logic [ADDR_W-1:0]     i_req_addr,
   output logic                  i_rsp_valid,
   output logic [DATA_W-1:0]     i_rsp_data,
   output logic                  i_rsp_err,
   input  logic                  d_req_valid,
   output logic                  d_req_ready,
   input  logic                  d_req_we,
   input  logic [ADDR_W-1:0]     d_req_addr,
   input  logic [DATA_W-1:0]     d_req_wdata,
   input  logic [DATA_W/8-1:0]   d_req_wstrb,
   output logic                  d_rsp_valid,
   output logic [DATA_W-1:0]     d_rsp_data,
   output logic                  d_rsp_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata
);

   localparam int STRB_W = DATA_W / 8;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT must be >= 1");
   end

   logic [1:0]        state_q, state_d;
   logic              last_d_q, last_d_d;    // 1 when D holds the most recent grant
   logic              owner_d_q, owner_d_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
   logic              i_vld_q, i_vld_d, d_vld_q, d_vld_d;
   logic              i_err_q, i_err_d, d_err_q, d_err_d;
   logic [DATA_W-1:0] i_data_q, i_data_d, d_data_q, d_data_d;
   logic              grant_i, grant_d, timeout;
   logic [DATA_W-1:0] rsp_data;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign timeout = (state_q == S_WAIT) && !mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

   // Counter sits at zero outside MEM_WAIT, so it is clear on entry.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q != S_WAIT) cnt_d = '0;
      else if (!mem_ack)     cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   // Grants depend only on the two valids and last_grant, never on payloads.
   assign grant_i  = (state_q == S_IDLE) && i_req_valid && (!d_req_valid || last_d_q);
   assign grant_d  = (state_q == S_IDLE) && d_req_valid && !grant_i;
   assign rsp_data = (owner_d_q && mem_we_q) ? '0 : mem_rdata;

   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      owner_d_d   = owner_d_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      i_data_d    = i_data_q;
      d_data_d    = d_data_q;
      i_vld_d     = 1'b0;
      d_vld_d     = 1'b0;
      i_err_d     = 1'b0;
      d_err_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_i) begin
               state_d     = S_WAIT;
               last_d_d    = 1'b0;
               owner_d_d   = 1'b0;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = i_req_addr;
               mem_wdata_d = '0;
               mem_wstrb_d = '0;
            end else if (grant_d) begin
               state_d     = S_WAIT;
               last_d_d    = 1'b1;
               owner_d_d   = 1'b1;
               mem_req_d   = 1'b1;
               mem_we_d    = d_req_we;
               mem_addr_d  = d_req_addr;
               mem_wdata_d = d_req_wdata;
               mem_wstrb_d = d_req_wstrb;
            end
         end
         S_WAIT: begin
            // A late ack in the final timeout cycle still produces a normal response.
            if (mem_ack || timeout) begin
               state_d   = S_RESP;
               mem_req_d = 1'b0;
               if (owner_d_q) begin
                  d_vld_d  = 1'b1;
                  d_err_d  = !mem_ack;
                  d_data_d = mem_ack ? rsp_data : '0;
               end else begin
                  i_vld_d  = 1'b1;
                  i_err_d  = !mem_ack;
                  i_data_d = mem_ack ? rsp_data : '0;
               end
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         last_d_q    <= 1'b1;
         owner_d_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         i_vld_q     <= 1'b0;
         d_vld_q     <= 1'b0;
         i_err_q     <= 1'b0;
         d_err_q     <= 1'b0;
         i_data_q    <= '0;
         d_data_q    <= '0;
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         owner_d_q   <= owner_d_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         i_vld_q     <= i_vld_d;
         d_vld_q     <= d_vld_d;
         i_err_q     <= i_err_d;
         d_err_q     <= d_err_d;
         i_data_q    <= i_data_d;
         d_data_q    <= d_data_d;
      end
   end

   assign i_req_ready = grant_i;
   assign d_req_ready = grant_d;
   assign i_rsp_valid = i_vld_q;
   assign i_rsp_data  = i_data_q;
   assign i_rsp_err   = i_err_q;
   assign d_rsp_valid = d_vld_q;
   assign d_rsp_data  = d_data_q;
   assign d_rsp_err   = d_err_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_wstrb   = mem_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model with per-cycle compare plus directed literal checks.
module tb_mem_port_arbiter;
   localparam int AW  = 64;
   localparam int DW  = 64;
   localparam int SW  = DW / 8;
   localparam int TMO = 4;
   localparam logic [63:0] RD_PAT = 64'hDEAD_BEEF_0000_0000;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          i_req_valid = 1'b0;
   logic [AW-1:0] i_req_addr = '0;
   logic          d_req_valid = 1'b0;
   logic          d_req_we = 1'b0;
   logic [AW-1:0] d_req_addr = '0;
   logic [DW-1:0] d_req_wdata = '0;
   logic [SW-1:0] d_req_wstrb = '0;
   logic          mem_ack = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          i_req_ready, i_rsp_valid, i_rsp_err;
   logic          d_req_ready, d_rsp_valid, d_rsp_err;
   logic [DW-1:0] i_rsp_data, d_rsp_data, mem_wdata;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [SW-1:0] mem_wstrb;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
      .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
      .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int glog[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic          m_busy, m_resp, m_last_d, m_owner_d, m_pick_d;
   int            m_unacked;
   logic          exp_mem_req, exp_mem_we;
   logic [AW-1:0] exp_mem_addr;
   logic [DW-1:0] exp_mem_wdata;
   logic [SW-1:0] exp_mem_wstrb;
   logic          exp_i_vld, exp_d_vld, exp_i_err, exp_d_err;
   logic [DW-1:0] exp_i_data, exp_d_data;

   task m_finish(input logic err, input logic [DW-1:0] data);
      m_busy = 1'b0;
      m_resp = 1'b1;
      exp_mem_req = 1'b0;
      if (m_owner_d) begin exp_d_vld = 1'b1; exp_d_err = err; exp_d_data = data; end
      else           begin exp_i_vld = 1'b1; exp_i_err = err; exp_i_data = data; end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy = 1'b0; m_resp = 1'b0; m_last_d = 1'b1; m_owner_d = 1'b0; m_unacked = 0;
         exp_mem_req = 1'b0; exp_mem_we = 1'b0; exp_mem_addr = '0; exp_mem_wdata = '0;
         exp_mem_wstrb = '0; exp_i_vld = 1'b0; exp_d_vld = 1'b0; exp_i_err = 1'b0;
         exp_d_err = 1'b0; exp_i_data = '0; exp_d_data = '0;
      end else if (m_resp) begin
         m_resp = 1'b0;
         exp_i_vld = 1'b0; exp_d_vld = 1'b0; exp_i_err = 1'b0; exp_d_err = 1'b0;
      end else if (m_busy) begin
         if (mem_ack) m_finish(1'b0, (m_owner_d && exp_mem_we) ? '0 : mem_rdata);
         else begin
            m_unacked++;
`ifdef MEM_ARB_TIMEOUT_EN
            if (m_unacked == TMO) m_finish(1'b1, '0);
`endif
         end
      end else if (i_req_valid || d_req_valid) begin
         m_pick_d = d_req_valid && (!i_req_valid || !m_last_d);
         m_busy = 1'b1; m_unacked = 0; m_owner_d = m_pick_d; m_last_d = m_pick_d;
         exp_mem_req = 1'b1;
         if (m_pick_d) begin
            exp_mem_we = d_req_we; exp_mem_addr = d_req_addr;
            exp_mem_wdata = d_req_wdata; exp_mem_wstrb = d_req_wstrb;
         end else begin
            exp_mem_we = 1'b0; exp_mem_addr = i_req_addr;
            exp_mem_wdata = '0; exp_mem_wstrb = '0;
         end
      end
   end

   always @(negedge clk) begin : cmp
      logic ei, ed;
      if (reset) begin
         ei = !m_busy && !m_resp && i_req_valid && (!d_req_valid || m_last_d);
         ed = !m_busy && !m_resp && d_req_valid && !ei;
         chk("i_req_ready", i_req_ready, ei);
         chk("d_req_ready", d_req_ready, ed);
         chk("mem_req", mem_req, exp_mem_req);
         chk("mem_we", mem_we, exp_mem_we);
         chk("mem_addr", mem_addr, exp_mem_addr);
         chk("mem_wdata", mem_wdata, exp_mem_wdata);
         chk("mem_wstrb", mem_wstrb, exp_mem_wstrb);
         chk("i_rsp_valid", i_rsp_valid, exp_i_vld);
         chk("d_rsp_valid", d_rsp_valid, exp_d_vld);
         chk("i_rsp_data", i_rsp_data, exp_i_data);
         chk("d_rsp_data", d_rsp_data, exp_d_data);
         chk("i_rsp_err", i_rsp_err, exp_i_err);
         chk("d_rsp_err", d_rsp_err, exp_d_err);
         if (i_req_valid && i_req_ready) glog.push_back(0);
         if (d_req_valid && d_req_ready) glog.push_back(1);
      end
   end

   // ---------------- memory responder and stimulus ----------------
   logic          ack_en = 1'b1;
   int            ack_wait = 0;
   int            req_cyc = 0;
   logic          stray_ack = 1'b0;
   logic          fixed_mode = 1'b0;
   logic [DW-1:0] fixed_rdata = '0;

   task automatic step();
      @(posedge clk);
      #1;
      if (mem_req && ack_en) begin
         mem_ack = (req_cyc == ack_wait);
         req_cyc++;
      end else begin
         mem_ack = mem_req ? 1'b0 : stray_ack;
         req_cyc = 0;
      end
      mem_rdata = fixed_mode ? fixed_rdata : (mem_addr ^ RD_PAT);
   endtask

   task automatic do_reset();
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin
      int cnt;
      #1;
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_i_rsp_valid", i_rsp_valid, 1'b0);
      chk("rst_d_rsp_valid", d_rsp_valid, 1'b0);
      chk("rst_mem_addr", mem_addr, 64'h0);
      do_reset();

      // Fetch, zero-wait memory
      fixed_mode = 1'b1; fixed_rdata = 64'h13; ack_wait = 0;
      step();
      i_req_valid = 1'b1; i_req_addr = 64'h8000_0000;
      step();
      i_req_valid = 1'b0;
      chk("t1_mem_req_c1", mem_req, 1'b1);
      chk("t1_mem_addr", mem_addr, 64'h8000_0000);
      step();
      chk("t1_mem_req_c2", mem_req, 1'b0);
      chk("t1_i_rsp_valid_c2", i_rsp_valid, 1'b1);
      chk("t1_i_rsp_data", i_rsp_data, 64'h13);
      step();
      chk("t1_i_rsp_valid_c3", i_rsp_valid, 1'b0);

      // Round-robin with both ports busy
      do_reset();
      fixed_mode = 1'b0;
      glog.delete();
      i_req_valid = 1'b1; i_req_addr = 64'h100;
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 64'h200;
      cnt = 0;
      while (glog.size() < 4 && cnt < 60) begin step(); cnt++; end
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      chk("t2_accepts", glog.size(), 4);
      if (glog.size() >= 4) begin
         chk("t2_grant0", glog[0], 0);
         chk("t2_grant1", glog[1], 1);
         chk("t2_grant2", glog[2], 0);
         chk("t2_grant3", glog[3], 1);
      end
      repeat (4) step();

      // Store with three wait cycles; a brief I valid during MEM_WAIT must be ignored
      ack_wait = 3;
      d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 64'h8000_1000;
      d_req_wdata = 64'h1122_3344_5566_7788; d_req_wstrb = 8'h0F;
      step();
      d_req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("t3_mem_req", mem_req, 1'b1);
         chk("t3_mem_we", mem_we, 1'b1);
         chk("t3_mem_addr", mem_addr, 64'h8000_1000);
         chk("t3_mem_wdata", mem_wdata, 64'h1122_3344_5566_7788);
         chk("t3_mem_wstrb", mem_wstrb, 8'h0F);
         i_req_valid = (k == 1);
         i_req_addr  = 64'h300;
         step();
      end
      i_req_valid = 1'b0;
      chk("t3_d_rsp_valid", d_rsp_valid, 1'b1);
      chk("t3_d_rsp_data", d_rsp_data, 64'h0);
      chk("t3_mem_req_done", mem_req, 1'b0);
      repeat (3) step();

      // Reset during MEM_WAIT
      ack_en = 1'b0; ack_wait = 0; d_req_we = 1'b0;
      i_req_valid = 1'b1; i_req_addr = 64'h400; d_req_valid = 1'b1; d_req_addr = 64'h500;
      step();
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      step();
      chk("t4_mem_req_wait", mem_req, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("t4_mem_req_rst", mem_req, 1'b0);
      chk("t4_mem_addr_rst", mem_addr, 64'h0);
      chk("t4_d_rsp_data_rst", d_rsp_data, 64'h0);
      chk("t4_i_rsp_valid_rst", i_rsp_valid, 1'b0);
      step();
      step();
      reset = 1'b1; ack_en = 1'b1;
      glog.delete();
      i_req_valid = 1'b1; d_req_valid = 1'b1;
      cnt = 0;
      while (glog.size() < 1 && cnt < 10) begin step(); cnt++; end
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      chk("t4_accepts", glog.size(), 1);
      if (glog.size() >= 1) chk("t4_first_grant", glog[0], 0);
      repeat (4) step();

      // Stray acks while IDLE and during RESP
      stray_ack = 1'b1;
      step();
      stray_ack = 1'b0;
      step();
      chk("t5_idle_mem_req", mem_req, 1'b0);
      chk("t5_idle_d_rsp", d_rsp_valid, 1'b0);
      chk("t5_idle_i_rsp", i_rsp_valid, 1'b0);
      d_req_valid = 1'b1; d_req_addr = 64'h600;
      step();
      d_req_valid = 1'b0;
      stray_ack = 1'b1;
      step();
      stray_ack = 1'b0;
      chk("t5_resp_d_rsp", d_rsp_valid, 1'b1);
      chk("t5_resp_d_data", d_rsp_data, 64'h600 ^ RD_PAT);
      step();
      chk("t5_after_d_rsp", d_rsp_valid, 1'b0);
      chk("t5_after_mem_req", mem_req, 1'b0);
      repeat (2) step();

`ifdef MEM_ARB_TIMEOUT_EN
      // Timeout with no ack, then ack arriving in the last allowed cycle
      for (int r = 0; r < 2; r++) begin
         ack_en = (r == 1); ack_wait = 3;
         d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 64'h700 + 64'(r);
         step();
         d_req_valid = 1'b0;
         cnt = 0;
         while (mem_req && cnt < 20) begin cnt++; step(); end
         chk("t6_req_cycles", cnt, 4);
         chk("t6_d_rsp_valid", d_rsp_valid, 1'b1);
         chk("t6_d_rsp_err", d_rsp_err, (r == 0));
         chk("t6_d_rsp_data", d_rsp_data, (r == 0) ? 64'h0 : ((64'h700 + 64'(r)) ^ RD_PAT));
         repeat (3) step();
      end
      ack_en = 1'b1;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
